lif_multineuron_accum: RTL and testbench

- Downstream consumer of the candidate FIFO output stream (neuron id + intersection score).
- Keeps one membrane potential register per neuron and adds accepted candidate scores to it during a timestep.
- On a timestep boundary it sweeps all neurons in order, applying leak and threshold compare and emitting one spike event per firing neuron over a valid/ready port.

---
 rtl/lif_pkg.sv | 34 +++
 rtl/lif_leak_fire.sv | 26 ++
 rtl/lif_multineuron_accum.sv | 131 +++++++++++++
 tb/tb_lif_multineuron_accum.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types, sizing and arithmetic helpers for the multi-neuron LIF accumulator.
// The optional subtractive reset is selected by the LIF_SOFT_RESET_EN macro (see lif_leak_fire).
package lif_pkg;

    localparam int NEURON_ID_W        = 4;
    localparam int SCORE_W            = 5;
    localparam int V_W                = 12;
    localparam int DEFAULT_LEAK_SHIFT = 3;
    localparam int NUM_NEURONS        = 2 ** NEURON_ID_W;

    typedef enum logic [1:0] {
        ACCUM,
        SWEEP,
        EMIT,
        DONE
    } lif_state_e;

    // Membrane plus zero-extended score, clamped at full scale instead of wrapping.
    function automatic logic [V_W-1:0] sat_add(input logic [V_W-1:0]     v,
                                               input logic [SCORE_W-1:0] s);
        logic [V_W:0] sum;
        sum = {1'b0, v} + {{(V_W + 1 - SCORE_W){1'b0}}, s};
        return sum[V_W] ? {V_W{1'b1}} : sum[V_W-1:0];
    endfunction

    // Shift of zero disables the leak entirely rather than draining the membrane.
    function automatic logic [V_W-1:0] leak(input logic [V_W-1:0] v, input int shift);
        if (shift == 0) begin
            return v;
        end
        return v - (v >> shift);
    endfunction

endpackage

// File: rtl/lif_leak_fire.sv
// Combinational leak, threshold compare and post-decision membrane value for one neuron.
// LIF_SOFT_RESET_EN keeps the residual above threshold on fire; otherwise the membrane is cleared.
module lif_leak_fire
    import lif_pkg::*;
#(
    parameter int LEAK_SHIFT = DEFAULT_LEAK_SHIFT
) (
    input  logic [V_W-1:0] v,
    input  logic [V_W-1:0] thr,
    output logic           fire,
    output logic [V_W-1:0] v_next
);

    logic [V_W-1:0] vl;

    always_comb begin
        vl   = leak(v, LEAK_SHIFT);
        fire = (vl >= thr);
`ifdef LIF_SOFT_RESET_EN
        v_next = fire ? (vl - thr) : vl;
`else
        v_next = fire ? '0 : vl;
`endif
    end

endmodule

// File: rtl/lif_multineuron_accum.sv
// Per-neuron membrane accumulator with a timestep-end leak/fire sweep and spike output port.
// Reset behaviour on fire is chosen by LIF_SOFT_RESET_EN (subtractive when defined, hard otherwise).
module lif_multineuron_accum
    import lif_pkg::*;
#(
    parameter int LEAK_SHIFT = DEFAULT_LEAK_SHIFT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cand_valid,
    output logic                   cand_ready,
    input  logic [NEURON_ID_W-1:0] cand_neuron,
    input  logic [SCORE_W-1:0]     cand_score,
    input  logic                   timestep_end,
    input  logic [V_W-1:0]         v_threshold,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic [NEURON_ID_W-1:0] spike_neuron,
    output logic                   sweep_done,
    output logic                   busy,
    output logic                   ts_overrun
);

    lif_state_e             state_q, state_d;
    logic [NEURON_ID_W-1:0] idx_q, idx_d;
    logic [V_W-1:0]         thr_q, thr_d;
    logic [V_W-1:0]         v_q [NUM_NEURONS];
    logic [V_W-1:0]         v_d [NUM_NEURONS];
    logic                   spike_valid_q, spike_valid_d;
    logic [NEURON_ID_W-1:0] spike_neuron_q, spike_neuron_d;
    logic                   sweep_done_q, sweep_done_d;
    logic                   ts_overrun_q, ts_overrun_d;
    logic                   fire;
    logic [V_W-1:0]         v_next;

    lif_leak_fire #(
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_leak_fire (
        .v      (v_q[idx_q]),
        .thr    (thr_q),
        .fire   (fire),
        .v_next (v_next)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        thr_d          = thr_q;
        v_d            = v_q;
        spike_valid_d  = spike_valid_q;
        spike_neuron_d = spike_neuron_q;
        ts_overrun_d   = ts_overrun_q | (timestep_end && (state_q != ACCUM));
        // Registered from the current state so the pulse follows the DONE cycle by one clock.
        sweep_done_d   = (state_q == DONE);

        case (state_q)
            ACCUM: begin
                // A candidate landing with timestep_end still belongs to the closing timestep.
                if (cand_valid) begin
                    v_d[cand_neuron] = sat_add(v_q[cand_neuron], cand_score);
                end
                if (timestep_end) begin
                    thr_d   = v_threshold;
                    idx_d   = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                v_d[idx_q] = v_next;
                if (fire) begin
                    spike_neuron_d = idx_q;
                    spike_valid_d  = 1'b1;
                    state_d        = EMIT;
                end else if (&idx_q) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + NEURON_ID_W'(1);
                end
            end
            EMIT: begin
                if (spike_ready) begin
                    spike_valid_d = 1'b0;
                    if (&idx_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + NEURON_ID_W'(1);
                        state_d = SWEEP;
                    end
                end
            end
            DONE: begin
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            idx_q          <= '0;
            thr_q          <= '0;
            spike_valid_q  <= 1'b0;
            spike_neuron_q <= '0;
            sweep_done_q   <= 1'b0;
            ts_overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            thr_q          <= thr_d;
            spike_valid_q  <= spike_valid_d;
            spike_neuron_q <= spike_neuron_d;
            sweep_done_q   <= sweep_done_d;
            ts_overrun_q   <= ts_overrun_d;
            v_q            <= v_d;
        end
    end

    assign cand_ready   = (state_q == ACCUM);
    assign busy         = (state_q != ACCUM);
    assign spike_valid  = spike_valid_q;
    assign spike_neuron = spike_neuron_q;
    assign sweep_done   = sweep_done_q;
    assign ts_overrun   = ts_overrun_q;

endmodule

// File: tb/tb_lif_multineuron_accum.sv
// Randomized self-checking bench for lif_multineuron_accum against an array-based LIF model.
// Honours LIF_SOFT_RESET_EN in the model so both reset flavours can be exercised.
module tb_lif_multineuron_accum;
    import lif_pkg::*;

    localparam int N    = NUM_NEURONS;
    localparam int LS   = DEFAULT_LEAK_SHIFT;
    localparam int VMAX = (1 << V_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   cand_valid;
    logic                   cand_ready;
    logic [NEURON_ID_W-1:0] cand_neuron;
    logic [SCORE_W-1:0]     cand_score;
    logic                   timestep_end;
    logic [V_W-1:0]         v_threshold;
    logic                   spike_valid;
    logic                   spike_ready;
    logic [NEURON_ID_W-1:0] spike_neuron;
    logic                   sweep_done;
    logic                   busy;
    logic                   ts_overrun;

    int n_checks;
    int n_pass;
    int mv [N];
    bit ovr_m;

    lif_multineuron_accum #(
        .LEAK_SHIFT(LS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cand_valid   (cand_valid),
        .cand_ready   (cand_ready),
        .cand_neuron  (cand_neuron),
        .cand_score   (cand_score),
        .timestep_end (timestep_end),
        .v_threshold  (v_threshold),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_neuron (spike_neuron),
        .sweep_done   (sweep_done),
        .busy         (busy),
        .ts_overrun   (ts_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int m_leak(input int v);
        return (LS == 0) ? v : v - (v >> LS);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mv[i] = 0;
        ovr_m = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        cand_valid   = 1'b0;
        timestep_end = 1'b0;
        spike_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cand(input int n, input int s);
        cand_valid  = 1'b1;
        cand_neuron = NEURON_ID_W'(n);
        cand_score  = SCORE_W'(s);
        check("cand_ready_accum", 32'(cand_ready), 1);
        @(negedge clk);
        cand_valid = 1'b0;
        mv[n] = (mv[n] + s > VMAX) ? VMAX : mv[n] + s;
    endtask

    // rmode: 0 always ready, 1 ready only after 5 stalled cycles, 2 random
    task automatic sweep(input int thr, input int rmode, input bit wc, input int cn, input int cs,
                         input bit ovr, input bit chk_lat);
        int exp_q[$];
        int got_q[$];
        int done_at, sd_cnt, hold, prev_sn, vl;
        bit prev_pend, r;
        timestep_end = 1'b1;
        v_threshold  = V_W'(thr);
        if (wc) begin
            cand_valid  = 1'b1;
            cand_neuron = NEURON_ID_W'(cn);
            cand_score  = SCORE_W'(cs);
            mv[cn] = (mv[cn] + cs > VMAX) ? VMAX : mv[cn] + cs;
        end
        for (int i = 0; i < N; i++) begin
            vl = m_leak(mv[i]);
            if (vl >= thr) begin
                exp_q.push_back(i);
`ifdef LIF_SOFT_RESET_EN
                mv[i] = vl - thr;
`else
                mv[i] = 0;
`endif
            end else begin
                mv[i] = vl;
            end
        end
        @(negedge clk);
        timestep_end = 1'b0;
        cand_valid   = 1'b0;
        v_threshold  = V_W'($urandom_range(0, VMAX));
        done_at = 0; sd_cnt = 0; hold = 0; prev_sn = 0; prev_pend = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (sweep_done) begin
                sd_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (prev_pend) begin
                check("spike_hold_valid", 32'(spike_valid), 1);
                check("spike_hold_id", 32'(spike_neuron), 32'(prev_sn));
            end
            if (done_at == 0) check("cand_ready_busy", 32'(cand_ready), 0);
            if (spike_valid) begin
                hold++;
                r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (hold > 5) : 1'($urandom_range(0, 1));
            end else begin
                hold = 0;
                r = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            spike_ready = r;
            if (spike_valid && r) begin
                got_q.push_back(int'(spike_neuron));
                prev_pend = 1'b0;
                hold = 0;
            end else if (spike_valid) begin
                prev_pend = 1'b1;
                prev_sn   = int'(spike_neuron);
            end else begin
                prev_pend = 1'b0;
            end
            if (ovr && k == 3) begin
                timestep_end = 1'b1;
                ovr_m = 1'b1;
            end
            if (ovr && k == 4) timestep_end = 1'b0;
            if (done_at != 0 && k >= done_at + 3) break;
            @(negedge clk);
        end
        spike_ready  = 1'b0;
        timestep_end = 1'b0;
        check("sweep_done_seen", 32'(done_at != 0), 1);
        check("sweep_done_count", 32'(sd_cnt), 1);
        if (chk_lat) check("sweep_latency", 32'(done_at), 18);
        check("spike_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("spike_id", 32'(got_q[i]), 32'(exp_q[i]));
        check("busy_after", 32'(busy), 0);
        check("spike_valid_after", 32'(spike_valid), 0);
        check("cand_ready_after", 32'(cand_ready), 1);
        check("ts_overrun", 32'(ts_overrun), 32'(ovr_m));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; cand_valid = 1'b0; cand_neuron = '0; cand_score = '0;
        timestep_end = 1'b0; v_threshold = '0; spike_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_cand_ready", 32'(cand_ready), 1);
        check("rst_spike_valid", 32'(spike_valid), 0);
        check("rst_spike_neuron", 32'(spike_neuron), 0);
        check("rst_sweep_done", 32'(sweep_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ts_overrun", 32'(ts_overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Accumulate three scores then fire neuron 3 on leaked 42 >= 40
        repeat (3) cand(3, 16);
        sweep(40, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        // Saturation: 300 x 16 must clamp at full scale; leaked 3584 fires only without wrap
        repeat (300) cand(0, 16);
        sweep(3584, 0, 1'b0, 0, 0, 1'b0, 1'b0);

        // No-fire latency, then the leaked residue 18 -> 16 fires at threshold 16
        do_reset();
        cand(5, 20);
        sweep(100, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        sweep(16, 0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Backpressure on three firing neurons
        do_reset();
        cand(1, 31); cand(2, 31); cand(15, 31);
        sweep(20, 1, 1'b0, 0, 0, 1'b0, 1'b0);

        // Candidate in the timestep_end cycle counts toward this sweep
        do_reset();
        sweep(9, 0, 1'b1, 7, 10, 1'b0, 1'b0);

        // Overrun pulse mid-sweep
        cand(6, 25); cand(9, 30);
        sweep(12, 2, 1'b0, 0, 0, 1'b1, 1'b0);

        // Reset while a spike is pending in EMIT
        cand(4, 31); cand(4, 31);
        timestep_end = 1'b1;
        v_threshold  = V_W'(1);
        @(negedge clk);
        timestep_end = 1'b0;
        spike_ready  = 1'b0;
        for (int i = 0; i < 40 && !spike_valid; i++) @(negedge clk);
        check("emit_reached", 32'(spike_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_emit_spike_valid", 32'(spike_valid), 0);
        check("rst_emit_busy", 32'(busy), 0);
        check("rst_emit_cand_ready", 32'(cand_ready), 1);
        check("rst_emit_ts_overrun", 32'(ts_overrun), 0);
        check("rst_emit_spike_neuron", 32'(spike_neuron), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        sweep(1, 0, 1'b0, 0, 0, 1'b0, 1'b1);

        // Zero threshold: every neuron fires in order
        sweep(0, 2, 1'b0, 0, 0, 1'b0, 1'b0);

        // Randomized timesteps
        for (int it = 0; it < 15; it++) begin
            int nc;
            nc = $urandom_range(0, 20);
            for (int j = 0; j < nc; j++) cand($urandom_range(0, N - 1), $urandom_range(0, 31));
            sweep($urandom_range(0, 150), 2, 1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
                  $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
